// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter.
//   exe_wb_inf_t : result packet presented by an execute unit
//   wb_entry_t   : the part of a packet that is buffered in a source FIFO
//   wb_src_e     : execute source identifiers, also used as the grant index
package wb_arbiter_pkg;

  localparam int WB_NUM_SRC = 3;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MUL = 2'd1,
    WB_SRC_LSU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic        instruction_valid;
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } exe_wb_inf_t;

  typedef struct packed {
    logic        register_write;
    logic [4:0]  rd;
    logic [31:0] exe_result;
  } wb_entry_t;

  // Next source in round-robin order, wrapping LSU -> ALU.
  function automatic wb_src_e wb_src_inc(wb_src_e s);
    logic [1:0] v;
    v = s;
    if (s == WB_SRC_LSU) return WB_SRC_ALU;
    return wb_src_e'(v + 2'd1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-source result FIFO, flop storage, combinational head.
// Ports:
//   clk, rst        clock, async active-high reset
//   push, push_data write request and entry
//   pop             read request (issued by the arbiter grant)
//   head_data       oldest entry; bypasses push_data while empty
//   empty, count    occupancy
//   overflow_pulse  a push was dropped because the FIFO was full and not popped
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_write;
  logic             do_read;

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // An empty FIFO can still be popped in the cycle it is pushed: the entry
  // flows straight through. Both pointers advance, so occupancy is unchanged.
  assign do_read        = pop && (!empty || push);
  assign do_write       = push && (!full || do_read);
  assign overflow_pulse = push && !do_write;
  assign head_data      = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers ALU/MUL/LSU results and grants one per cycle to
// the register-file write port in round-robin order.
// Ports:
//   clk, rst                   clock, async active-high reset
//   alu/mul/lsu_wb_inf         result packets from the execute units
//   wb_full[2:0]               per-source throttle (0=ALU, 1=MUL, 2=LSU)
//   rf_we, rf_waddr, rf_wdata  registered register-file write
//   retire_valid, instret      retire strobe and 64-bit retired count
//   wb_overflow                sticky: a push was dropped on a full FIFO
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SRC    = WB_NUM_SRC
) (
  input  logic               clk,
  input  logic               rst,
  input  exe_wb_inf_t        alu_wb_inf,
  input  exe_wb_inf_t        mul_wb_inf,
  input  exe_wb_inf_t        lsu_wb_inf,
  output logic [NUM_SRC-1:0] wb_full,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               retire_valid,
  output logic [63:0]        instret,
  output logic               wb_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  // Two entries of slack cover the dispatcher -> unit -> arbiter pipeline.
  localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(FIFO_DEPTH - 2);

  exe_wb_inf_t        src_in    [NUM_SRC];
  wb_entry_t          push_data [NUM_SRC];
  wb_entry_t          head_data [NUM_SRC];
  logic [CNT_W-1:0]   count     [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] avail;
  logic [NUM_SRC-1:0] ovf_pulse;

  wb_src_e   last_grant;
  wb_src_e   grant_src;
  wb_src_e   cand;
  logic      grant_valid;
  wb_entry_t sel;

  assign src_in[WB_SRC_ALU] = alu_wb_inf;
  assign src_in[WB_SRC_MUL] = mul_wb_inf;
  assign src_in[WB_SRC_LSU] = lsu_wb_inf;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign push[g]      = src_in[g].instruction_valid;
    assign push_data[g] = '{register_write: src_in[g].register_write,
                            rd:             src_in[g].rd,
                            exe_result:     src_in[g].exe_result};
    // A packet arriving this cycle is eligible even if its FIFO is empty.
    assign avail[g]     = !empty[g] || push[g];
    assign wb_full[g]   = (count[g] >= FULL_THRESH);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push           (push[g]),
      .push_data      (push_data[g]),
      .pop            (pop[g]),
      .head_data      (head_data[g]),
      .empty          (empty[g]),
      .count          (count[g]),
      .overflow_pulse (ovf_pulse[g])
    );
  end

  // Search last_grant+1, +2, then last_grant itself.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = last_grant;
    cand        = last_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = wb_src_inc(cand);
      if (!grant_valid && avail[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_valid && (grant_src == wb_src_e'(i));
    end
  end

  assign sel = head_data[grant_src];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= WB_SRC_LSU;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      retire_valid <= 1'b0;
      instret      <= '0;
      wb_overflow  <= 1'b0;
    end else begin
      retire_valid <= grant_valid;
      rf_we        <= grant_valid && sel.register_write && (sel.rd != 5'd0);
      if (grant_valid) begin
        rf_waddr   <= sel.rd;
        rf_wdata   <= sel.exe_result;
        last_grant <= grant_src;
      end
      if (retire_valid) instret <= instret + 64'd1;
      if (|ovf_pulse) wb_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  exe_wb_inf_t alu_in, mul_in, lsu_in;
  logic [2:0]  wb_full;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [63:0] instret;
  logic        wb_overflow;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .NUM_SRC(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_wb_inf   (alu_in),
    .mul_wb_inf   (mul_in),
    .lsu_wb_inf   (lsu_in),
    .wb_full      (wb_full),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire_valid (retire_valid),
    .instret      (instret),
    .wb_overflow  (wb_overflow)
  );

  typedef struct {
    bit        rw;
    bit [4:0]  rd;
    bit [31:0] data;
  } pkt_t;

  typedef struct {
    bit        retire;
    bit        we;
    bit [4:0]  waddr;
    bit [31:0] wdata;
    bit [63:0] instret;
    bit [2:0]  full;
    bit        ovf;
  } exp_t;

  exp_t            exp_q[$];
  pkt_t            mq[3][$];
  pkt_t            cur[3];
  int              m_last;
  longint unsigned m_instret;
  bit              m_ovf;
  int              passes = 0;
  int              total  = 0;
  exp_t            mon_e;

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.rw   = ($urandom % 4) != 0;
    p.rd   = 5'($urandom_range(0, 31));
    p.data = $urandom;
    return p;
  endfunction

  // Drive one cycle of inputs (called just after a posedge), record what the
  // outputs must look like after the coming edge, then advance.
  task automatic cycle(input bit [2:0] v);
    bit [2:0] avail;
    int       g;
    exp_t     e;
    pkt_t     h;
    alu_in = '{v[0], cur[0].rw, cur[0].rd, cur[0].data};
    mul_in = '{v[1], cur[1].rw, cur[1].rd, cur[1].data};
    lsu_in = '{v[2], cur[2].rw, cur[2].rd, cur[2].data};
    g = -1;
    for (int i = 0; i < 3; i++) avail[i] = (mq[i].size() > 0) || v[i];
    for (int k = 1; k <= 3; k++) begin
      int s;
      s = (m_last + k) % 3;
      if (g < 0 && avail[s]) g = s;
    end
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        if (mq[i].size() == DEPTH && g != i) m_ovf = 1'b1;
        else mq[i].push_back(cur[i]);
      end
    end
    e.instret = m_instret;
    e.retire  = 1'b0;
    e.we      = 1'b0;
    e.waddr   = '0;
    e.wdata   = '0;
    if (g >= 0) begin
      h         = mq[g].pop_front();
      e.retire  = 1'b1;
      e.we      = h.rw && (h.rd != 5'd0);
      e.waddr   = h.rd;
      e.wdata   = h.data;
      m_last    = g;
      m_instret = m_instret + 1;
    end
    for (int i = 0; i < 3; i++) e.full[i] = (mq[i].size() >= DEPTH - 2);
    e.ovf = m_ovf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
      cycle(3'b000);
    end
  endtask

  // Assert reset at the current time, check the async reset values, and
  // release it just after a posedge.
  task automatic assert_reset();
    exp_t e;
    rst = 1'b1;
    alu_in = '0;
    mul_in = '0;
    lsu_in = '0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_retire_valid", retire_valid, 0);
    chk("rst_instret", instret, 0);
    chk("rst_wb_overflow", wb_overflow, 0);
    chk("rst_wb_full", wb_full, 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) mq[i].delete();
    m_last    = 2;
    m_instret = 0;
    m_ovf     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    e.retire  = 1'b0;
    e.we      = 1'b0;
    e.waddr   = '0;
    e.wdata   = '0;
    e.instret = '0;
    e.full    = '0;
    e.ovf     = 1'b0;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL scoreboard_underflow: DUT output cycle with no expectation at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("retire_valid", retire_valid, mon_e.retire);
        chk("rf_we", rf_we, mon_e.we);
        if (mon_e.retire) begin
          chk("rf_waddr", rf_waddr, mon_e.waddr);
          chk("rf_wdata", rf_wdata, mon_e.wdata);
        end
        chk("instret", instret, mon_e.instret);
        chk("wb_full", wb_full, mon_e.full);
        chk("wb_overflow", wb_overflow, mon_e.ovf);
      end
    end
  end

  initial begin
    bit [2:0] v;
    rst    = 1'b1;
    alu_in = '0;
    mul_in = '0;
    lsu_in = '0;
    for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
    assert_reset();

    // Single ALU packet.
    cur[0] = '{1'b1, 5'd5, 32'hDEADBEEF};
    cycle(3'b001);
    idle(3);

    // All three sources in the same cycle.
    cur[0] = '{1'b1, 5'd1, 32'h1111_0001};
    cur[1] = '{1'b1, 5'd2, 32'h2222_0002};
    cur[2] = '{1'b1, 5'd3, 32'h3333_0003};
    cycle(3'b111);
    idle(4);

    // Retires without a register write.
    cur[2] = '{1'b0, 5'd7, 32'hCAFE_0007};
    cycle(3'b100);
    cur[0] = '{1'b1, 5'd0, 32'h0BAD_0000};
    cycle(3'b001);
    idle(3);

    // Streaming with a dispatcher stub that honours the full flags.
    for (int c = 0; c < 60; c++) begin
      for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
      v[0] = (mq[0].size() < DEPTH - 2) && ($urandom % 4 != 0);
      v[1] = (mq[1].size() < DEPTH - 2);
      v[2] = (mq[2].size() < DEPTH - 2) && ($urandom % 4 != 0);
      cycle(v);
    end
    idle(6);
    chk("stream_no_overflow", wb_overflow, 0);

    // Ignore the full flags until FIFOs overflow.
    for (int c = 0; c < 12; c++) begin
      for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
      cycle(3'b111);
    end
    idle(14);
    chk("overflow_sticky", wb_overflow, 1);

    // Random mix, full flags ignored.
    for (int c = 0; c < 80; c++) begin
      for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
      cycle(3'($urandom_range(0, 7)));
    end

    // Reset mid-operation with packets buffered.
    for (int c = 0; c < 2; c++) begin
      for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
      cycle(3'b111);
    end
    #2;
    assert_reset();
    idle(5);
    for (int j = 0; j < 3; j++) cur[j] = rand_pkt();
    cycle(3'b111);
    idle(5);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
